// File: rtl/snn_pkg.sv
// Shared constants, FSM state encoding and the saturating arithmetic used by
// the leaky integrate-and-fire core.
package snn_pkg;

  localparam int NUM_NEURONS_DEF     = 64;
  localparam int NEURON_ID_WIDTH_DEF = 6;
  localparam int WEIGHT_WIDTH_DEF    = 16;
  localparam int V_WIDTH             = 16;
  localparam int R_WIDTH             = 8;
  localparam int STATE_WIDTH         = R_WIDTH + V_WIDTH;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_STEP = 2;

  localparam int CFG_RESET_MODE = 0;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_SWEEP     = 1;
  localparam int STAT_CLEAR     = 2;
  localparam int STAT_STEP_OVF  = 3;
  localparam int STAT_SPK_STALL = 4;
  localparam int STAT_TS_LSB    = 16;

  // CLEAR is the all-zero encoding so reset lands there directly.
  typedef enum logic [2:0] {
    ST_CLEAR    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_EVT_RD   = 3'd2,
    ST_EVT_WR   = 3'd3,
    ST_SPK_WAIT = 3'd4,
    ST_LK_RD    = 3'd5,
    ST_LK_WR    = 3'd6
  } state_e;

  function automatic logic [V_WIDTH-1:0] sat_add(input logic [V_WIDTH-1:0] v,
                                                 input logic [WEIGHT_WIDTH_DEF-1:0] w);
    logic signed [17:0] sum;
    sum = $signed({2'b00, v}) + $signed({{2{w[WEIGHT_WIDTH_DEF-1]}}, w});
    if (sum < 18'sd0) return '0;
    else if (sum > 18'sd65535) return '1;
    else return sum[V_WIDTH-1:0];
  endfunction

  function automatic logic [V_WIDTH-1:0] leak_sub(input logic [V_WIDTH-1:0] v,
                                                  input logic [V_WIDTH-1:0] leak);
    return (v > leak) ? v - leak : '0;
  endfunction

endpackage

// File: rtl/lif_neuron_core_if.sv
// Event input and spike output streams of the LIF core.
// Both streams: a beat transfers on a clock edge where valid and ready are both
// high; valid and its payload stay stable until that edge, ready never waits on valid.
interface lif_neuron_core_if #(
  parameter int ID_W = 6,
  parameter int W_W  = 16
);
  logic            s_evt_valid;
  logic            s_evt_ready;
  logic [ID_W-1:0] s_evt_id;
  logic [W_W-1:0]  s_evt_weight;
  logic            m_spk_valid;
  logic            m_spk_ready;
  logic [ID_W-1:0] m_spk_id;

  modport slave (
    input  s_evt_valid, s_evt_id, s_evt_weight, m_spk_ready,
    output s_evt_ready, m_spk_valid, m_spk_id
  );

  modport master (
    output s_evt_valid, s_evt_id, s_evt_weight, m_spk_ready,
    input  s_evt_ready, m_spk_valid, m_spk_id
  );
endinterface

// File: rtl/neuron_state_ram.sv
// Per-neuron {refractory, potential} storage: one write port, one registered
// read port; a same-address read and write returns the old word.
module neuron_state_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/lif_neuron_core.sv
// Time-multiplexed leaky integrate-and-fire engine: integrates weighted events,
// leaks once per timestep and emits spike IDs.
module lif_neuron_core
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS     = NUM_NEURONS_DEF,
  parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
  parameter int WEIGHT_WIDTH    = WEIGHT_WIDTH_DEF
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [31:0]          ctrl_reg,
  input  logic [31:0]          config_reg,
  input  logic [15:0]          leak_rate,
  input  logic [15:0]          threshold,
  input  logic [15:0]          refractory_period,
  lif_neuron_core_if.slave     bus,
  output logic [31:0]          status_reg,
  output logic [31:0]          spike_count,
  output state_e               dbg_state_o
);
  state_e state_q, state_d;
  logic [NEURON_ID_WIDTH-1:0] idx_q, evt_id_q, spk_id_q;
  logic [WEIGHT_WIDTH-1:0]    evt_w_q;
  logic clr_prev_q, step_prev_q, clr_pend_q, step_pend_q;
  logic spk_valid_q, ovf_q, stall_q;
  logic [31:0] spk_cnt_q;
  logic [15:0] ts_q;

  logic ram_we, ram_re, evt_ready;
  logic [NEURON_ID_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [STATE_WIDTH-1:0] ram_wdata, ram_rdata;

  logic enable, clr_edge, step_edge, evt_acc, step_take, last_idx;
  logic spk_free, fire, spk_load;
  logic [V_WIDTH-1:0] rd_v, v_int, v_new;
  logic [R_WIDTH-1:0] rd_r, r_new, refr_clip;
  logic unused_bits;

  assign unused_bits = ^{ctrl_reg[31:3], config_reg[31:1]};

  assign enable    = ctrl_reg[CTRL_EN];
  assign clr_edge  = ctrl_reg[CTRL_CLR] & ~clr_prev_q;
  assign step_edge = ctrl_reg[CTRL_STEP] & ~step_prev_q & enable;
  assign last_idx  = (idx_q == NEURON_ID_WIDTH'(NUM_NEURONS - 1));
  assign evt_acc   = bus.s_evt_valid & evt_ready;
  assign step_take = (state_q == ST_IDLE) & ~clr_pend_q & step_pend_q & enable;

  assign rd_v      = ram_rdata[V_WIDTH-1:0];
  assign rd_r      = ram_rdata[STATE_WIDTH-1:V_WIDTH];
  assign refr_clip = (|refractory_period[15:8]) ? 8'hFF : refractory_period[7:0];

  // Integration result; only meaningful in EVT_WR when the neuron is not refractory.
  assign v_int = sat_add(rd_v, evt_w_q);
  assign fire  = (rd_r == '0) && (v_int >= threshold);
  assign v_new = fire ? (config_reg[CFG_RESET_MODE] ? v_int - threshold : '0) : v_int;
  assign r_new = fire ? refr_clip : rd_r;

  // The spike register can take a new ID if empty or draining this very edge.
  assign spk_free = ~spk_valid_q | bus.m_spk_ready;
  assign spk_load = ((state_q == ST_EVT_WR) & fire & spk_free) |
                    ((state_q == ST_SPK_WAIT) & spk_free);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_CLEAR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:    if (last_idx) state_d = ST_IDLE;
      ST_IDLE: begin
        if (clr_pend_q)                    state_d = ST_CLEAR;
        else if (step_pend_q && enable)    state_d = ST_LK_RD;
        else if (evt_acc)                  state_d = ST_EVT_RD;
      end
      ST_EVT_RD:   state_d = ST_EVT_WR;
      ST_EVT_WR:   state_d = (fire && !spk_free) ? ST_SPK_WAIT : ST_IDLE;
      ST_SPK_WAIT: if (spk_free) state_d = ST_IDLE;
      ST_LK_RD:    state_d = ST_LK_WR;
      ST_LK_WR:    state_d = last_idx ? ST_IDLE : ST_LK_RD;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = idx_q;
    ram_raddr = idx_q;
    ram_wdata = '0;
    evt_ready = (state_q == ST_IDLE) & enable & ~clr_pend_q & ~step_pend_q;
    case (state_q)
      ST_CLEAR:  ram_we = 1'b1;
      ST_EVT_RD: begin
        ram_re    = 1'b1;
        ram_raddr = evt_id_q;
      end
      // Refractory neurons drop the event without touching memory.
      ST_EVT_WR: begin
        ram_we    = (rd_r == '0);
        ram_waddr = evt_id_q;
        ram_wdata = {r_new, v_new};
      end
      ST_LK_RD:  ram_re = 1'b1;
      ST_LK_WR: begin
        ram_we    = 1'b1;
        ram_wdata = {(rd_r != '0) ? rd_r - 8'd1 : 8'd0, leak_sub(rd_v, leak_rate)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q       <= '0;
      evt_id_q    <= '0;
      evt_w_q     <= '0;
      clr_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      step_pend_q <= 1'b0;
      spk_valid_q <= 1'b0;
      spk_id_q    <= '0;
      spk_cnt_q   <= '0;
      ts_q        <= '0;
      ovf_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      clr_prev_q  <= ctrl_reg[CTRL_CLR];
      step_prev_q <= ctrl_reg[CTRL_STEP];
      if (evt_acc) begin
        evt_id_q <= bus.s_evt_id;
        evt_w_q  <= bus.s_evt_weight;
      end
      if (state_q == ST_CLEAR || state_q == ST_LK_WR) idx_q <= last_idx ? '0 : idx_q + 1'b1;
      if (state_q == ST_CLEAR) begin
        clr_pend_q  <= 1'b0;
        step_pend_q <= 1'b0;
        spk_valid_q <= 1'b0;
        spk_id_q    <= '0;
        spk_cnt_q   <= '0;
        ts_q        <= '0;
        ovf_q       <= 1'b0;
        stall_q     <= 1'b0;
      end else begin
        if (clr_edge) clr_pend_q <= 1'b1;
        // One step runs, one more may wait; any further step is dropped.
        if (step_edge) begin
          if (step_pend_q && !step_take) ovf_q <= 1'b1;
          step_pend_q <= 1'b1;
        end else if (step_take) begin
          step_pend_q <= 1'b0;
        end
        if (spk_load) begin
          spk_valid_q <= 1'b1;
          spk_id_q    <= evt_id_q;
        end else if (spk_valid_q && bus.m_spk_ready) begin
          spk_valid_q <= 1'b0;
        end
        if (state_q == ST_EVT_WR && fire) spk_cnt_q <= spk_cnt_q + 32'd1;
        if (state_q == ST_EVT_WR && state_d == ST_SPK_WAIT) stall_q <= 1'b1;
        if (state_q == ST_LK_WR && last_idx) ts_q <= ts_q + 16'd1;
      end
    end
  end

  neuron_state_ram #(
    .DEPTH(NUM_NEURONS),
    .AW   (NEURON_ID_WIDTH),
    .DW   (STATE_WIDTH)
  ) u_ram (
    .clk    (aclk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign bus.s_evt_ready = evt_ready;
  assign bus.m_spk_valid = spk_valid_q;
  assign bus.m_spk_id    = spk_id_q;
  assign spike_count     = spk_cnt_q;
  assign dbg_state_o     = state_q;
  assign status_reg      = {ts_q, 11'd0, stall_q, ovf_q, state_q == ST_CLEAR,
                            state_q == ST_LK_RD || state_q == ST_LK_WR, state_q != ST_IDLE};
endmodule
